// File: rtl/io_serial_tx_if.sv
// CPU io port pair as seen by the serial transmitter.
// cpu_out carries the CPU's ioout byte; cpu_in returns status on the CPU's ioin byte.
interface io_serial_tx_if;
    logic [7:0] cpu_out;
    logic [7:0] cpu_in;

    modport master (output cpu_out, input  cpu_in);
    modport slave  (input  cpu_out, output cpu_in);
endinterface

// File: rtl/io_serial_tx.sv
// Serial transmitter on the CPU io port pair.
// The CPU posts 7-bit characters with a toggle handshake on cpu_out[7].
// Accepted characters go into a small FIFO and are sent on tx as
// start bit, 7 data bits LSB first, then a stop bit. Each bit lasts DIVISOR clocks.
// Status returns on cpu_in = {ack_tgl, full, busy, empty, 4'b0000}.
//
// state | meaning
// IDLE  | line high; pop the next character as soon as the FIFO is not empty
// START | start bit (line low) for DIVISOR clocks
// DATA  | 7 data bits, LSB first, each DIVISOR clocks
// STOP  | stop bit (line high) for DIVISOR clocks, then one IDLE clock
module io_serial_tx #(
    parameter int DIVISOR    = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    io_serial_tx_if.slave cpu,
    output logic          tx
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int DIV_W = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIVISOR - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // CPU side
    logic [7:0] out_q;
    logic       req_seen_q, req_seen_d;
    logic       ack_tgl_q, ack_tgl_d;
    logic [7:0] cpu_in_q, cpu_in_d;

    // FIFO
    logic [6:0]       mem_q [FIFO_DEPTH];
    logic [6:0]       mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d;
    logic [PTR_W-1:0] rd_q, rd_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Transmitter
    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [6:0]       sh_q, sh_d;
    logic             tx_q, tx_d;

    logic full;
    logic empty;
    logic pending;
    logic push;
    logic pop;

    // Handshake and FIFO bookkeeping. A pop in the same cycle frees a slot,
    // so a pending request is accepted on the pop edge even when the FIFO is full.
    always_comb begin
        full       = (count_q == CNT_FULL);
        empty      = (count_q == '0);
        pending    = (out_q[7] != req_seen_q);
        pop        = (state_q == IDLE) && !empty;
        push       = pending && (!full || pop);

        req_seen_d = req_seen_q;
        ack_tgl_d  = ack_tgl_q;
        mem_d      = mem_q;
        wr_d       = wr_q;
        rd_d       = rd_q;
        count_d    = count_q;

        if (push) begin
            mem_d[wr_q] = out_q[6:0];
            wr_d        = wr_q + PTR_W'(1);
            req_seen_d  = out_q[7];
            ack_tgl_d   = ~ack_tgl_q;
        end
        if (pop) begin
            rd_d = rd_q + PTR_W'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Transmit FSM next state: every line level is held for exactly DIVISOR clocks.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        tx_d    = tx_q;

        unique case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (pop) begin
                    sh_d    = mem_q[rd_q];
                    tx_d    = 1'b0;
                    div_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                if (div_q == DIV_LAST) begin
                    div_d   = '0;
                    cnt_d   = '0;
                    tx_d    = sh_q[0];
                    state_d = DATA;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            DATA: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (cnt_q == 3'd6) begin
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        sh_d  = {1'b0, sh_q[6:1]};
                        tx_d  = sh_q[1];
                        cnt_d = cnt_q + 3'd1;
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            STOP: begin
                if (div_q == DIV_LAST) begin
                    div_d   = '0;
                    state_d = IDLE;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    // Status byte is built from next-state values so it lines up with the flops it reports.
    always_comb begin
        cpu_in_d = {ack_tgl_d, (count_d == CNT_FULL), (state_d != IDLE),
                    (count_d == '0), 4'b0000};
    end

    // All state registers; reset empties the FIFO and idles the line immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q      <= '0;
            req_seen_q <= 1'b0;
            ack_tgl_q  <= 1'b0;
            cpu_in_q   <= 8'b0001_0000;
            mem_q      <= '{default: '0};
            wr_q       <= '0;
            rd_q       <= '0;
            count_q    <= '0;
            state_q    <= IDLE;
            div_q      <= '0;
            cnt_q      <= '0;
            sh_q       <= '0;
            tx_q       <= 1'b1;
        end else begin
            out_q      <= cpu.cpu_out;
            req_seen_q <= req_seen_d;
            ack_tgl_q  <= ack_tgl_d;
            cpu_in_q   <= cpu_in_d;
            mem_q      <= mem_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            count_q    <= count_d;
            state_q    <= state_d;
            div_q      <= div_d;
            cnt_q      <= cnt_d;
            sh_q       <= sh_d;
            tx_q       <= tx_d;
        end
    end

    assign cpu.cpu_in = cpu_in_q;
    assign tx         = tx_q;

endmodule

// File: tb/tb_io_serial_tx.sv
// Bench for io_serial_tx: a 16/4 instance for the directed tests and a 2/2 instance
// for the random-character run. Stimulus queues expected characters; a separate
// monitor decodes frames on the selected tx line and checks every bit cycle.
module tb_io_serial_tx;
    localparam int DIV_M = 16;
    localparam int DEP_M = 4;
    localparam int DIV_S = 2;
    localparam int DEP_S = 2;

    logic clk = 1'b0;
    logic rst;
    logic tx_m;
    logic tx_s;

    io_serial_tx_if if_m ();
    io_serial_tx_if if_s ();

    io_serial_tx #(.DIVISOR(DIV_M), .FIFO_DEPTH(DEP_M)) dut_m (
        .clk(clk), .rst(rst), .cpu(if_m.slave), .tx(tx_m));
    io_serial_tx #(.DIVISOR(DIV_S), .FIFO_DEPTH(DEP_S)) dut_s (
        .clk(clk), .rst(rst), .cpu(if_s.slave), .tx(tx_s));

    always #5 clk = ~clk;

    int         total = 0;
    int         bad   = 0;
    logic [6:0] exp_q [$];
    bit         sel      = 1'b0;
    bit         tgl_m    = 1'b0;
    bit         tgl_s    = 1'b0;
    bit         mon_busy = 1'b0;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, req);
        end
    endtask

    // Post one character with a fresh toggle and wait (bounded) for the ack bit to follow.
    task automatic send(input bit s, input logic [6:0] ch, output int lat);
        bit   t;
        logic ack;
        t = s ? ~tgl_s : ~tgl_m;
        if (s) begin
            tgl_s = t;
            if_s.cpu_out = {t, ch};
        end else begin
            tgl_m = t;
            if_m.cpu_out = {t, ch};
        end
        exp_q.push_back(ch);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            ack = s ? if_s.cpu_in[7] : if_m.cpu_in[7];
        end while (ack != t && lat < 1000);
        if (lat >= 1000) check("ack_timeout", 0, 1);
    endtask

    // Wait (bounded) until the selected transmitter is idle with nothing left to send.
    task automatic drain(input bit s);
        int         n;
        logic [7:0] ci;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            ci = s ? if_s.cpu_in : if_m.cpu_in;
        end while (!(ci[4] && !ci[5] && !mon_busy && exp_q.size() == 0) && n < 5000);
        check("drain", int'(n < 5000), 1);
    endtask

    // Frame monitor: checks each clock of a frame against the expected character.
    initial begin : monitor
        logic [6:0] want;
        logic [6:0] got;
        bit         shape_ok;
        bit         aborted;
        int         dv;
        int         b;
        logic       lvl;
        logic       exp_lvl;
        forever begin
            @(negedge clk);
            dv  = sel ? DIV_S : DIV_M;
            lvl = sel ? tx_s : tx_m;
            if (!rst && lvl === 1'b0) begin
                mon_busy = 1'b1;
                if (exp_q.size() == 0) begin
                    check("unexpected_frame", 1, 0);
                    want = '0;
                end else begin
                    want = exp_q.pop_front();
                end
                got      = '0;
                shape_ok = 1'b1;
                aborted  = 1'b0;
                for (int k = 0; k < 9 * dv; k++) begin
                    if (k > 0) begin
                        @(negedge clk);
                        lvl = sel ? tx_s : tx_m;
                    end
                    if (rst) begin
                        aborted = 1'b1;
                        break;
                    end
                    b = k / dv;
                    exp_lvl = (b == 0) ? 1'b0 : (b == 8) ? 1'b1 : want[b-1];
                    if (lvl !== exp_lvl) shape_ok = 1'b0;
                    if (b >= 1 && b <= 7 && (k % dv) == dv / 2) got[b-1] = lvl;
                end
                if (!aborted) begin
                    check("frame_char", int'(got), int'(want));
                    check("frame_shape", int'(shape_ok), 1);
                end
                mon_busy = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin : stimulus
        int         lat;
        int         n;
        logic [6:0] ch;

        rst = 1'b1;
        if_m.cpu_out = 8'h00;
        if_s.cpu_out = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_cpu_in_m", int'(if_m.cpu_in), 8'h10);
        check("reset_cpu_in_s", int'(if_s.cpu_in), 8'h10);
        check("reset_tx_m", int'(tx_m), 1);
        rst = 1'b0;

        // Idle with no request: nothing changes for 100 cycles.
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx_m !== 1'b1 || if_m.cpu_in !== 8'h10) n++;
        end
        check("idle_hold", n, 0);

        // Single character 'A': ack two clocks after the write, 144 busy cycles.
        tgl_m = 1'b1;
        if_m.cpu_out = 8'hC1;
        exp_q.push_back(7'h41);
        @(negedge clk);
        check("ack_after_e0", int'(if_m.cpu_in[7]), 0);
        @(negedge clk);
        check("ack_after_e1", int'(if_m.cpu_in[7]), 1);
        check("empty_after_push", int'(if_m.cpu_in[4]), 0);
        @(negedge clk);
        check("busy_after_pop", int'(if_m.cpu_in[5]), 1);
        check("empty_after_pop", int'(if_m.cpu_in[4]), 1);
        n = 1;
        forever begin
            @(negedge clk);
            if (!if_m.cpu_in[5] || n >= 400) break;
            n++;
        end
        check("busy_len", n, 144);
        drain(1'b0);

        // Back-to-back writes: first five accepted fast, sixth waits for a pop.
        for (int i = 1; i <= 5; i++) begin
            send(1'b0, 7'(i), lat);
            check($sformatf("ack_lat_%0d", i), lat, 2);
            check($sformatf("full_after_%0d", i), int'(if_m.cpu_in[6]), (i == 5) ? 1 : 0);
        end
        send(1'b0, 7'h06, lat);
        check("ack_lat_6_delayed", int'(lat > 20), 1);
        check("full_after_push_pop", int'(if_m.cpu_in[6]), 1);
        drain(1'b0);
        check("full_after_drain", int'(if_m.cpu_in[6]), 0);

        // Reset in the middle of data bit 3.
        send(1'b0, 7'h55, lat);
        repeat (71) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_tx", int'(tx_m), 1);
        check("async_rst_cpu_in", int'(if_m.cpu_in), 8'h10);
        exp_q.delete();
        tgl_m = 1'b1;
        if_m.cpu_out = 8'hB3;
        exp_q.push_back(7'h33);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        // Toggle bit already high at release counts as a new request.
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (if_m.cpu_in[7] !== 1'b1 && n < 100);
        check("ack_after_release", n, 2);
        drain(1'b0);
        send(1'b0, 7'h2A, lat);
        check("ack_lat_post_rst", lat, 2);
        drain(1'b0);

        // Small instance: random characters through a 2-deep FIFO at 2 clocks per bit.
        sel = 1'b1;
        for (int i = 0; i < 20; i++) begin
            ch = 7'($urandom_range(0, 127));
            send(1'b1, ch, lat);
        end
        drain(1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
